key_event_filter: RTL and testbench
===================================

KEY_EVENT_FILTER -- requirements
Module: key_event_filter

Interface
REQ-001 SHALL have parameter NO_KEY, default 4'd9, meaning the scanner's idle code; any code 9..15 is treated as no key.
REQ-002 SHALL have parameter HIT_CNT, default 3, meaning the number of matching samples needed to confirm a press.
REQ-003 SHALL have parameter MISS_CNT, default 8, meaning consecutive non-matching samples needed to abandon a candidate or declare a release; must be >4.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, meaning the event queue depth.
REQ-005 SHALL have port clk_100Hz, input, 1 bit: 100 Hz clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port key_value, input, 4 bits: decoded code from the keypad scanner; 0..8 means a key was sampled.
REQ-008 SHALL have port ev_ready, input, 1 bit: consumer accepts the head event.
REQ-009 SHALL have port ev_valid, output, 1 bit: the FIFO is non-empty.
REQ-010 SHALL have port ev_key, output, 4 bits: the key code at the FIFO head.
REQ-011 SHALL have port ev_count, output, 3 bits: FIFO occupancy, 0..4.
REQ-012 SHALL have port key_down, output, 1 bit: high while in the HELD state.
REQ-013 SHALL have port overflow, output, 1 bit: sticky flag set when a confirmed press is dropped.

Function
REQ-014 SHALL sample key_value once per clk_100Hz rising edge; a sample is a "hit c" if key_value = c ≤ 8, else a "miss".
REQ-015 SHALL implement the FSM states IDLE, CAND and HELD, with registers cand[3:0], hits and miss.
REQ-016 In IDLE, a hit c SHALL set cand=c, hits=1, miss=0 and move to CAND; a miss SHALL keep the block in IDLE.
REQ-017 In CAND, a hit on cand SHALL increment hits and clear miss.
REQ-018 In CAND, when hits reaches HIT_CNT, the block SHALL push cand into the FIFO and move to HELD in the same edge.
REQ-019 In CAND, a hit on d≠cand SHALL restart the candidate: cand=d, hits=1, miss=0.
REQ-020 In CAND, a miss SHALL increment miss; at miss=MISS_CNT the block SHALL go to IDLE with no event.
REQ-021 In HELD, a hit on cand SHALL clear miss.
REQ-022 In HELD, a miss or a hit on a different code SHALL increment miss; at MISS_CNT the block SHALL go to IDLE (release), so at most one event is produced per press.
REQ-023 The block SHALL NOT auto-repeat an event while a key is held.
REQ-024 Push latency: ev_valid SHALL rise on the edge after the confirming sample when the FIFO was empty.
REQ-025 The FIFO SHALL be a circular buffer with wrapping head/tail pointers; ev_key = mem[head].
REQ-026 A pop SHALL occur when ev_valid && ev_ready; ev_ready while empty SHALL be ignored.
REQ-027 Simultaneous push and pop SHALL leave ev_count unchanged, including when the FIFO is full.
REQ-028 A push into a full FIFO without a pop SHALL drop the event and set overflow.
REQ-029 overflow SHALL be cleared only by reset.

Reset
REQ-030 While reset is high, asynchronously: state=IDLE, cand=0, hits=0, miss=0, head=tail=0, ev_count=0, ev_valid=0, ev_key=0, key_down=0, overflow=0.
REQ-031 Reset mid-press SHALL discard the candidate and all queued events; after release, a still-held key SHALL need HIT_CNT new hits before it produces an event.

Structure
REQ-032 NO_KEY, the state encoding and default HIT_CNT/MISS_CNT SHALL live in the shared package keypad_pkg.
REQ-033 The FIFO SHALL be a sub-module, key_fifo, parameterised by depth and width 4.

Verification
REQ-034 Key 5 sampled every 4th cycle for 40 cycles, then 9 (no key) -> exactly one event with ev_key=5; ev_valid is high 1 cycle after the 3rd hit; key_down falls 8 cycles after the last hit.
REQ-035 Samples 4, 9, 9, 9, 4 and then 9 for 10 cycles -> no event; state returns to IDLE.
REQ-036 Samples 2, 2, 7, 7, 7 -> one event with ev_key=7; no event for 2.
REQ-037 Five distinct confirmed presses (0, 1, 2, 3, 4) with ev_ready=0 -> ev_count=4, overflow=1, and pops return 0, 1, 2, 3.
REQ-038 FIFO full with ev_ready=1 on the same cycle as a new confirm (code 8) -> ev_count stays 4, overflow=0, and 8 is queued last.
REQ-039 Reset asserted during HELD with 2 events queued -> all outputs are 0 immediately, and the held key produces a new event only after 3 fresh hits.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad constants: idle scan code, debounce thresholds and filter FSM encoding.
package keypad_pkg;

  localparam logic [3:0] DEF_NO_KEY     = 4'd9;
  localparam int         DEF_HIT_CNT    = 3;
  localparam int         DEF_MISS_CNT   = 8;
  localparam int         DEF_FIFO_DEPTH = 4;
  localparam int         KEY_W          = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  // Any code at or above the idle code counts as "no key".
  function automatic logic is_hit(input logic [3:0] code, input logic [3:0] no_key);
    return code < no_key;
  endfunction

endpackage

// File: rtl/key_fifo.sv
// Circular event queue; push lands one edge later on pop_vld, pop on pop_vld && pop_rdy.
// When full, a push is accepted only alongside a pop; otherwise it is dropped and flagged.
module key_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_100Hz,
  input  logic             reset,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  output logic             push_drop,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign pop_vld   = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop_vld && pop_rdy;
  // A pop in the same edge frees the slot the tail is about to overwrite.
  assign do_push   = push_vld && (!full || do_pop);
  assign push_drop = push_vld && !do_push;
  assign pop_dat   = mem[head];

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_dat;
        tail      <= wrap_inc(tail);
      end
      if (do_pop) head <= wrap_inc(head);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/key_event_filter.sv
// Debounces scanner samples into one queued event per press; event visible the edge after the
// confirming sample. Consumer drains with ev_ready; a confirm into a full queue sets sticky overflow.
module key_event_filter
  import keypad_pkg::*;
#(
  parameter logic [3:0] NO_KEY     = DEF_NO_KEY,
  parameter int         HIT_CNT    = DEF_HIT_CNT,
  parameter int         MISS_CNT   = DEF_MISS_CNT,
  parameter int         FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic       clk_100Hz,
  input  logic       reset,
  input  logic [3:0] key_value,
  input  logic       ev_ready,
  output logic       ev_valid,
  output logic [3:0] ev_key,
  output logic [2:0] ev_count,
  output logic       key_down,
  output logic       overflow
);

  localparam int HW = $clog2(HIT_CNT + 1);
  localparam int MW = $clog2(MISS_CNT + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  state_t        state;
  logic [3:0]    cand;
  logic [HW-1:0] hits;
  logic [MW-1:0] miss;

  logic          sample_hit;
  logic          same_key;
  logic          push_vld;
  logic          push_drop;
  logic [CW-1:0] fifo_count;

  assign sample_hit = is_hit(key_value, NO_KEY);
  assign same_key   = sample_hit && (key_value == cand);

  // The confirming sample pushes on the same edge that enters HELD.
  always_comb begin
    push_vld = 1'b0;
    if (state == ST_CAND && same_key && hits == HW'(HIT_CNT - 1)) push_vld = 1'b1;
  end

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      cand     <= '0;
      hits     <= '0;
      miss     <= '0;
      key_down <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sample_hit) begin
            cand  <= key_value;
            hits  <= HW'(1);
            miss  <= '0;
            state <= ST_CAND;
          end
        end
        ST_CAND: begin
          if (same_key) begin
            hits <= hits + HW'(1);
            miss <= '0;
            if (push_vld) begin
              state    <= ST_HELD;
              key_down <= 1'b1;
            end
          end else if (sample_hit) begin
            cand <= key_value;
            hits <= HW'(1);
            miss <= '0;
          end else if (miss == MW'(MISS_CNT - 1)) begin
            state <= ST_IDLE;
            hits  <= '0;
            miss  <= '0;
          end else begin
            miss <= miss + MW'(1);
          end
        end
        ST_HELD: begin
          // A different key while held only counts toward release, never a new event.
          if (same_key) begin
            miss <= '0;
          end else if (miss == MW'(MISS_CNT - 1)) begin
            state    <= ST_IDLE;
            key_down <= 1'b0;
            hits     <= '0;
            miss     <= '0;
          end else begin
            miss <= miss + MW'(1);
          end
        end
        default: begin
          state    <= ST_IDLE;
          key_down <= 1'b0;
        end
      endcase
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_W)
  ) u_fifo (
    .clk_100Hz (clk_100Hz),
    .reset     (reset),
    .push_vld  (push_vld),
    .push_dat  (cand),
    .push_drop (push_drop),
    .pop_vld   (ev_valid),
    .pop_rdy   (ev_ready),
    .pop_dat   (ev_key),
    .count     (fifo_count)
  );

  assign ev_count = 3'(fifo_count);

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset)          overflow <= 1'b0;
    else if (push_drop) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_key_event_filter.sv
// Directed bench for key_event_filter with a queue-based scoreboard checking every popped event.
module tb_key_event_filter;
  import keypad_pkg::*;

  logic       clk_100Hz = 1'b0;
  logic       reset;
  logic [3:0] key_value;
  logic       ev_ready;
  logic       ev_valid;
  logic [3:0] ev_key;
  logic [2:0] ev_count;
  logic       key_down;
  logic       overflow;

  int total = 0;
  int bad   = 0;
  int exp_q[$];

  key_event_filter dut (
    .clk_100Hz (clk_100Hz),
    .reset     (reset),
    .key_value (key_value),
    .ev_ready  (ev_ready),
    .ev_valid  (ev_valid),
    .ev_key    (ev_key),
    .ev_count  (ev_count),
    .key_down  (key_down),
    .overflow  (overflow)
  );

  always #5 clk_100Hz = ~clk_100Hz;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one sample, advance through its edge, return just after the edge.
  task automatic step(input logic [3:0] k, input logic rdy);
    key_value = k;
    ev_ready  = rdy;
    @(posedge clk_100Hz);
    #1;
  endtask

  task automatic press(input logic [3:0] k, input logic rdy, input bit expect_push);
    step(k, rdy);
    step(k, rdy);
    if (expect_push) exp_q.push_back(int'(k));
    step(k, rdy);
  endtask

  task automatic release_key(input logic rdy);
    for (int i = 0; i < 8; i++) step(4'd9, rdy);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ev_valid"}, int'(ev_valid), 0);
    chk({tag, "_ev_key"},   int'(ev_key),   0);
    chk({tag, "_ev_count"}, int'(ev_count), 0);
    chk({tag, "_key_down"}, int'(key_down), 0);
    chk({tag, "_overflow"}, int'(overflow), 0);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk_all_zero(tag);
    @(posedge clk_100Hz);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: a pop happens on the next edge whenever valid && ready here.
  always @(negedge clk_100Hz) begin
    if (!reset && ev_valid && ev_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got=%0d expected=none at %0t", ev_key, $time);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (int'(ev_key) != e) begin
          bad++;
          $display("FAIL pop_key: got=%0d expected=%0d at %0t", ev_key, e, $time);
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    key_value = 4'd9;
    ev_ready  = 1'b0;
    #2;
    chk_all_zero("por");
    @(posedge clk_100Hz);
    #1;
    reset = 1'b0;

    // Key 5 every 4th sample: one event, no repeat, release 8 samples after last hit.
    for (int i = 0; i < 40; i++) begin
      if (i == 8) exp_q.push_back(5);
      step((i % 4 == 0) ? 4'd5 : 4'd9, 1'b0);
      if (i == 4) chk("sparse_not_yet", int'(ev_valid), 0);
      if (i == 8) begin
        chk("sparse_valid", int'(ev_valid), 1);
        chk("sparse_keydown", int'(key_down), 1);
      end
    end
    for (int j = 4; j <= 10; j++) begin
      step(4'd9, 1'b0);
      if (j == 7) chk("sparse_held_7", int'(key_down), 1);
      if (j == 8) chk("sparse_release_8", int'(key_down), 0);
    end
    chk("sparse_one_event", int'(ev_count), 1);
    chk("sparse_head", int'(ev_key), 5);
    step(4'd9, 1'b1);
    chk("sparse_drained", int'(ev_count), 0);

    // Two scattered hits never confirm; candidate abandoned.
    step(4'd4, 1'b0);
    step(4'd9, 1'b0);
    step(4'd9, 1'b0);
    step(4'd9, 1'b0);
    step(4'd4, 1'b0);
    for (int i = 0; i < 10; i++) step(4'd9, 1'b0);
    chk("abandon_count", int'(ev_count), 0);
    chk("abandon_keydown", int'(key_down), 0);
    chk("abandon_idle", int'(dut.state), int'(ST_IDLE));

    // Candidate restart: 2,2 then 7,7,7.
    step(4'd2, 1'b0);
    step(4'd2, 1'b0);
    chk("restart_no2", int'(ev_count), 0);
    step(4'd7, 1'b0);
    step(4'd7, 1'b0);
    exp_q.push_back(7);
    step(4'd7, 1'b0);
    chk("restart_one", int'(ev_count), 1);
    chk("restart_head", int'(ev_key), 7);
    release_key(1'b1);
    chk("restart_drained", int'(ev_count), 0);
    chk("restart_released", int'(key_down), 0);

    // Five presses with no consumer: fifth dropped, sticky overflow.
    for (int k = 0; k < 5; k++) begin
      press(4'(k), 1'b0, k < 4);
      release_key(1'b0);
    end
    chk("ovf_count", int'(ev_count), 4);
    chk("ovf_flag", int'(overflow), 1);
    for (int i = 0; i < 4; i++) step(4'd9, 1'b1);
    chk("ovf_drained", int'(ev_count), 0);
    chk("ovf_sticky", int'(overflow), 1);

    do_reset("rst1");

    // Full queue, pop coincides with confirm of 8: no drop.
    for (int k = 0; k < 4; k++) begin
      press(4'(k), 1'b0, 1'b1);
      release_key(1'b0);
    end
    chk("full_count", int'(ev_count), 4);
    step(4'd8, 1'b0);
    step(4'd8, 1'b0);
    exp_q.push_back(8);
    step(4'd8, 1'b1);
    chk("full_swap_count", int'(ev_count), 4);
    chk("full_swap_ovf", int'(overflow), 0);
    chk("full_swap_head", int'(ev_key), 1);
    release_key(1'b1);
    chk("full_drained", int'(ev_count), 0);

    // Reset while held with two events queued; held key must re-confirm.
    press(4'd1, 1'b0, 1'b1);
    release_key(1'b0);
    press(4'd2, 1'b0, 1'b1);
    chk("mid_keydown", int'(key_down), 1);
    chk("mid_count", int'(ev_count), 2);
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk_all_zero("midrst");
    reset = 1'b0;
    step(4'd2, 1'b0);
    step(4'd2, 1'b0);
    chk("midrst_two_hits", int'(ev_valid), 0);
    exp_q.push_back(2);
    step(4'd2, 1'b0);
    chk("midrst_third_hit", int'(ev_valid), 1);
    chk("midrst_key", int'(ev_key), 2);
    release_key(1'b1);
    chk("midrst_drained", int'(ev_count), 0);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
